fosfor_present_regif: RTL and testbench

FOSFOR_PRESENT_REGIF -- requirements
Module: fosfor_present_regif

---
 rtl/fosfor_present_pkg.sv | 27 ++
 rtl/fosfor_present_regif_if.sv | 23 ++
 rtl/fosfor_present_watchdog.sv | 27 ++
 rtl/fosfor_present_regif.sv | 158 +++++++++++++++
 tb/tb_fosfor_present_regif.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fosfor_present_pkg.sv
// rtl/fosfor_present_pkg.sv - shared codes, status bit layout and FSM type for the PRESENT register interface
package fosfor_present_pkg;

   localparam logic [1:0] ADDR_NONE = 2'b00;
   localparam logic [1:0] ADDR_CMD  = 2'b01;
   localparam logic [1:0] ADDR_DLO  = 2'b10;
   localparam logic [1:0] ADDR_DHI  = 2'b11;

   localparam logic [3:0] CMD_NOP   = 4'h0;
   localparam logic [3:0] CMD_START = 4'h1;
   localparam logic [3:0] CMD_CLEAR = 4'h2;
   localparam logic [3:0] CMD_ABORT = 4'h3;

   localparam int ST_BUSY   = 0;
   localparam int ST_DONE   = 1;
   localparam int ST_ERR    = 2;
   localparam int ST_IVALID = 3;

   localparam logic [7:0] WDOG_LIMIT = 8'd255;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

endpackage

// File: rtl/fosfor_present_regif_if.sv
// rtl/fosfor_present_regif_if.sv - host register bus and core handshake bundle
interface fosfor_present_regif_if;

   logic [1:0] Addr_ib;
   logic [3:0] Data_ib;
   logic [7:0] Data_ob;
   logic [7:0] InputData_ob;
   logic       Start_o;
   logic       Abort_o;
   logic       Done_i;
   logic [7:0] OutputData_ib;

   modport master (
      output Addr_ib, Data_ib, Done_i, OutputData_ib,
      input  Data_ob, InputData_ob, Start_o, Abort_o
   );

   modport slave (
      input  Addr_ib, Data_ib, Done_i, OutputData_ib,
      output Data_ob, InputData_ob, Start_o, Abort_o
   );

endinterface

// File: rtl/fosfor_present_watchdog.sv
// rtl/fosfor_present_watchdog.sv - cycle counter that flags a core run taking too long
module fosfor_present_watchdog
   import fosfor_present_pkg::*;
(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   logic [7:0] r_count;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != WDOG_LIMIT)) begin
         r_count <= r_count + 8'd1;
      end
   end

   // Fires on the cycle whose increment would bring the count to the limit.
   assign o_expired = i_enable && (r_count == (WDOG_LIMIT - 8'd1));

endmodule

// File: rtl/fosfor_present_regif.sv
// rtl/fosfor_present_regif.sv - nibble-wide register interface sequencing one PRESENT core run
module fosfor_present_regif
   import fosfor_present_pkg::*;
(
   input  logic       Clk_ik,
   input  logic       Reset_ir,
   input  logic [1:0] Addr_ib,
   input  logic [3:0] Data_ib,
   output logic [7:0] Data_ob,
   output logic [7:0] InputData_ob,
   output logic       Start_o,
   output logic       Abort_o,
   input  logic       Done_i,
   input  logic [7:0] OutputData_ib
);

   state_t     r_state;
   logic [7:0] r_in_data;
   logic [7:0] r_out_data;
   logic [7:0] r_data_o;
   logic [3:0] r_last_cmd;
   logic       r_done;
   logic       r_err;
   logic       r_ivalid;
   logic       r_lo_seen;
   logic       r_hi_seen;
   logic       r_prev_cmd;
   logic       r_start_o;
   logic       r_abort_o;

   logic       w_busy;
   logic       w_cmd_exec;
   logic       w_wd_clear;
   logic       w_wd_enable;
   logic       w_wd_expired;
   logic [7:0] w_status;

   assign w_busy      = (r_state != S_IDLE);
   assign w_cmd_exec  = (Addr_ib == ADDR_CMD) && !r_prev_cmd;
   assign w_wd_clear  = (r_state == S_START);
   assign w_wd_enable = (r_state == S_WAIT);

   always_comb begin
      w_status            = '0;
      w_status[7:4]       = r_last_cmd;
      w_status[ST_IVALID] = r_ivalid;
      w_status[ST_ERR]    = r_err;
      w_status[ST_DONE]   = r_done;
      w_status[ST_BUSY]   = w_busy;
   end

   fosfor_present_watchdog u_watchdog (
      .i_clk     (Clk_ik),
      .i_rst     (Reset_ir),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_enable),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge Clk_ik or posedge Reset_ir) begin
      if (Reset_ir) begin
         r_state    <= S_IDLE;
         r_in_data  <= '0;
         r_out_data <= '0;
         r_data_o   <= '0;
         r_last_cmd <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_ivalid   <= 1'b0;
         r_lo_seen  <= 1'b0;
         r_hi_seen  <= 1'b0;
         r_prev_cmd <= 1'b0;
         r_start_o  <= 1'b0;
         r_abort_o  <= 1'b0;
      end else begin
         r_prev_cmd <= (Addr_ib == ADDR_CMD);
         r_start_o  <= 1'b0;
         r_abort_o  <= 1'b0;
         r_data_o   <= ((Addr_ib == ADDR_NONE) || (Addr_ib == ADDR_CMD)) ? w_status : r_out_data;

         // Data addresses are writes on every edge; the core input is frozen during a run.
         if ((Addr_ib == ADDR_DLO) || (Addr_ib == ADDR_DHI)) begin
            if (w_busy) begin
               r_err <= 1'b1;
            end else if (Addr_ib == ADDR_DLO) begin
               r_in_data[3:0] <= Data_ib;
               r_lo_seen      <= 1'b1;
               r_ivalid       <= r_ivalid | r_hi_seen;
            end else begin
               r_in_data[7:4] <= Data_ib;
               r_hi_seen      <= 1'b1;
               r_ivalid       <= r_ivalid | r_lo_seen;
            end
         end

         if (w_cmd_exec) begin
            r_last_cmd <= Data_ib;
            case (Data_ib)
               CMD_NOP: ;
               CMD_START: begin
                  if (w_busy || !r_ivalid) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state   <= S_START;
                     r_start_o <= 1'b1;
                     r_done    <= 1'b0;
                  end
               end
               CMD_CLEAR: begin
                  r_done    <= 1'b0;
                  r_err     <= 1'b0;
                  r_ivalid  <= 1'b0;
                  r_lo_seen <= 1'b0;
                  r_hi_seen <= 1'b0;
                  if (!w_busy) begin
                     r_in_data  <= '0;
                     r_out_data <= '0;
                  end
               end
               CMD_ABORT: ;
               default: r_err <= 1'b1;
            endcase
         end

         // FSM assignments come last so a completing run overrides a same-cycle CLEAR.
         case (r_state)
            S_IDLE: ;
            S_START: begin
               r_ivalid  <= 1'b0;
               r_lo_seen <= 1'b0;
               r_hi_seen <= 1'b0;
               r_state   <= S_WAIT;
            end
            S_WAIT: begin
               if (Done_i) begin
                  r_out_data <= OutputData_ib;
                  r_done     <= 1'b1;
                  r_state    <= S_IDLE;
               end else if (w_cmd_exec && (Data_ib == CMD_ABORT)) begin
                  r_abort_o <= 1'b1;
                  r_state   <= S_IDLE;
               end else if (w_wd_expired) begin
                  r_err     <= 1'b1;
                  r_abort_o <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Data_ob      = r_data_o;
   assign InputData_ob = r_in_data;
   assign Start_o      = r_start_o;
   assign Abort_o      = r_abort_o;

endmodule

// File: tb/tb_fosfor_present_regif.sv
// tb/tb_fosfor_present_regif.sv - scoreboard bench for fosfor_present_regif
module tb_fosfor_present_regif;
   import fosfor_present_pkg::*;

   logic Clk_ik   = 1'b0;
   logic Reset_ir = 1'b1;

   fosfor_present_regif_if bus ();

   fosfor_present_regif dut (
      .Clk_ik        (Clk_ik),
      .Reset_ir      (Reset_ir),
      .Addr_ib       (bus.Addr_ib),
      .Data_ib       (bus.Data_ib),
      .Data_ob       (bus.Data_ob),
      .InputData_ob  (bus.InputData_ob),
      .Start_o       (bus.Start_o),
      .Abort_o       (bus.Abort_o),
      .Done_i        (bus.Done_i),
      .OutputData_ib (bus.OutputData_ib)
   );

   always #5 Clk_ik = ~Clk_ik;

   int         n_checks  = 0;
   int         n_errors  = 0;
   int         start_cnt = 0;
   int         abort_cnt = 0;
   logic [7:0] exp_q[$];
   string      tag_q[$];

   always @(negedge Clk_ik) begin
      if (bus.Start_o === 1'b1) start_cnt++;
      if (bus.Abort_o === 1'b1) abort_cnt++;
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk_ik);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [3:0] d);
      bus.Addr_ib = a;
      bus.Data_ib = d;
      tick();
      bus.Addr_ib = ADDR_NONE;
      bus.Data_ib = 4'h0;
   endtask

   task automatic cmd(input logic [3:0] c);
      bus.Addr_ib = ADDR_NONE;
      tick();
      bus.Addr_ib = ADDR_CMD;
      bus.Data_ib = c;
      tick();
      bus.Addr_ib = ADDR_NONE;
      bus.Data_ib = 4'h0;
   endtask

   task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
      bus.Addr_ib = a;
      bus.Data_ib = 4'h0;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      tick();
      chk(tag_q.pop_front(), 16'(bus.Data_ob), 16'(exp_q.pop_front()));
      bus.Addr_ib = ADDR_NONE;
   endtask

   task automatic done_pulse(input logic [7:0] d);
      bus.Done_i        = 1'b1;
      bus.OutputData_ib = d;
      tick();
      bus.Done_i        = 1'b0;
   endtask

   initial begin
      int s0;
      int a0;
      int n;
      bus.Addr_ib       = ADDR_NONE;
      bus.Data_ib       = 4'h0;
      bus.Done_i        = 1'b0;
      bus.OutputData_ib = 8'h00;
      repeat (3) tick();
      Reset_ir = 1'b0;

      chk("rst_data_ob", 16'(bus.Data_ob), 16'h00);
      chk("rst_input_data", 16'(bus.InputData_ob), 16'h00);
      chk("rst_start", 16'(bus.Start_o), 16'h0);
      chk("rst_abort", 16'(bus.Abort_o), 16'h0);
      rd(ADDR_NONE, 8'h00, "rst_status");

      // basic run
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      chk("t1_input_data", 16'(bus.InputData_ob), 16'h00A5);
      rd(ADDR_NONE, 8'h08, "t1_ivalid");
      s0 = start_cnt;
      cmd(CMD_START);
      tick();
      rd(ADDR_NONE, 8'h11, "t1_busy");
      chk("t1_start_once", 16'(start_cnt - s0), 16'd1);
      done_pulse(8'h3C);
      rd(ADDR_DLO, 8'h3C, "t1_out");
      rd(ADDR_NONE, 8'h12, "t1_done");

      // held command executes once; START without input sets Err
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      s0 = start_cnt;
      bus.Addr_ib = ADDR_NONE;
      tick();
      bus.Addr_ib = ADDR_CMD;
      bus.Data_ib = CMD_START;
      repeat (10) tick();
      bus.Addr_ib = ADDR_NONE;
      tick();
      chk("t2_start_once", 16'(start_cnt - s0), 16'd1);
      done_pulse(8'h5A);
      rd(ADDR_NONE, 8'h12, "t2_done");
      cmd(CMD_CLEAR);
      rd(ADDR_NONE, 8'h20, "t2_clear");
      cmd(CMD_START);
      rd(ADDR_NONE, 8'h14, "t2_start_noinput");
      chk("t2_no_extra_start", 16'(start_cnt - s0), 16'd1);

      // abort in WAIT
      cmd(CMD_CLEAR);
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      cmd(CMD_START);
      tick();
      a0 = abort_cnt;
      cmd(CMD_ABORT);
      chk("t3_abort_high", 16'(bus.Abort_o), 16'h1);
      tick();
      chk("t3_abort_low", 16'(bus.Abort_o), 16'h0);
      chk("t3_abort_once", 16'(abort_cnt - a0), 16'd1);
      rd(ADDR_NONE, 8'h30, "t3_abort_status");

      // Done_i beats a same-cycle ABORT
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      cmd(CMD_START);
      tick();
      a0 = abort_cnt;
      bus.Addr_ib = ADDR_NONE;
      tick();
      bus.Addr_ib       = ADDR_CMD;
      bus.Data_ib       = CMD_ABORT;
      bus.Done_i        = 1'b1;
      bus.OutputData_ib = 8'h77;
      tick();
      bus.Done_i  = 1'b0;
      bus.Addr_ib = ADDR_NONE;
      chk("t3_race_no_abort", 16'(bus.Abort_o), 16'h0);
      tick();
      chk("t3_race_abort_cnt", 16'(abort_cnt - a0), 16'd0);
      rd(ADDR_NONE, 8'h32, "t3_race_status");
      rd(ADDR_DLO, 8'h77, "t3_race_out");

      // writes and CLEAR while busy
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      cmd(CMD_START);
      tick();
      wr(ADDR_DHI, 4'hF);
      chk("t4_busy_write_ignored", 16'(bus.InputData_ob), 16'h00A5);
      rd(ADDR_NONE, 8'h15, "t4_busy_err");
      cmd(CMD_CLEAR);
      rd(ADDR_NONE, 8'h21, "t4_busy_clear");
      chk("t4_busy_clear_data", 16'(bus.InputData_ob), 16'h00A5);
      done_pulse(8'h99);
      rd(ADDR_NONE, 8'h22, "t4_done");
      rd(ADDR_DLO, 8'h99, "t4_out");

      // watchdog expiry
      cmd(CMD_CLEAR);
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      cmd(CMD_START);
      chk("t5_start_pulse", 16'(bus.Start_o), 16'h1);
      n = 0;
      while ((bus.Abort_o !== 1'b1) && (n < 400)) begin
         tick();
         n++;
      end
      chk("t5_wd_cycles", 16'(n), 16'd256);
      rd(ADDR_NONE, 8'h14, "t5_wd_status");
      done_pulse(8'hEE);
      rd(ADDR_DLO, 8'h00, "t5_done_idle_out");
      rd(ADDR_NONE, 8'h14, "t5_done_idle_status");

      // illegal command then CLEAR
      cmd(CMD_CLEAR);
      rd(ADDR_NONE, 8'h20, "t6_clear");
      wr(ADDR_DHI, 4'hA);
      cmd(4'h7);
      rd(ADDR_NONE, 8'h74, "t6_illegal");
      chk("t6_illegal_keeps_data", 16'(bus.InputData_ob), 16'h00A0);
      cmd(CMD_CLEAR);
      rd(ADDR_NONE, 8'h20, "t6_clear2");
      chk("t6_clear_input", 16'(bus.InputData_ob), 16'h0000);
      rd(ADDR_DLO, 8'h00, "t6_clear_out");

      // asynchronous reset mid-WAIT
      wr(ADDR_DLO, 4'h5);
      wr(ADDR_DHI, 4'hA);
      cmd(CMD_START);
      tick();
      rd(ADDR_NONE, 8'h11, "t7_busy");
      #3;
      Reset_ir = 1'b1;
      #1;
      chk("t7_rst_data_ob", 16'(bus.Data_ob), 16'h00);
      chk("t7_rst_input", 16'(bus.InputData_ob), 16'h00);
      chk("t7_rst_start", 16'(bus.Start_o), 16'h0);
      chk("t7_rst_abort", 16'(bus.Abort_o), 16'h0);
      bus.Addr_ib = ADDR_CMD;
      bus.Data_ib = CMD_CLEAR;
      #2;
      Reset_ir = 1'b0;
      tick();
      bus.Addr_ib = ADDR_NONE;
      bus.Data_ib = 4'h0;
      rd(ADDR_NONE, 8'h20, "t7_first_cmd_after_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
